// File: rtl/scv_memarb_if.sv
// ----------------------------------------------------------------------------
// scv_memarb_if
// Bus bundle between the shared-RAM arbiter and its environment.
//   ROMINIT_* : download write stream (VALID held until the READY pulse)
//   CPU_*     : CPU read/write port (REQ held until the ACK pulse)
//   VID_*     : video read port (REQ held until the ACK pulse)
//   MEM_*     : single-port synchronous RAM, 1-cycle read latency
//   DL_ACTIVE : download in progress, blocks CPU/VID grants
// slave  : the arbiter side
// master : requesters + RAM side
// ----------------------------------------------------------------------------
interface scv_memarb_if #(
    parameter int AW = 18,
    parameter int DW = 8
);
    logic          DL_ACTIVE;
    logic          ROMINIT_SEL_BOOT;
    logic          ROMINIT_SEL_CHR;
    logic          ROMINIT_SEL_CART;
    logic [16:0]   ROMINIT_ADDR;
    logic [DW-1:0] ROMINIT_DATA;
    logic          ROMINIT_VALID;
    logic          ROMINIT_READY;
    logic          CPU_REQ;
    logic          CPU_WE;
    logic [AW-1:0] CPU_ADDR;
    logic [DW-1:0] CPU_DIN;
    logic          CPU_ACK;
    logic [DW-1:0] CPU_DOUT;
    logic          VID_REQ;
    logic [AW-1:0] VID_ADDR;
    logic          VID_ACK;
    logic [DW-1:0] VID_DOUT;
    logic          MEM_CE;
    logic          MEM_WE;
    logic [AW-1:0] MEM_ADDR;
    logic [DW-1:0] MEM_DIN;
    logic [DW-1:0] MEM_DOUT;

    modport slave (
        input  DL_ACTIVE, ROMINIT_SEL_BOOT, ROMINIT_SEL_CHR, ROMINIT_SEL_CART,
               ROMINIT_ADDR, ROMINIT_DATA, ROMINIT_VALID,
               CPU_REQ, CPU_WE, CPU_ADDR, CPU_DIN, VID_REQ, VID_ADDR, MEM_DOUT,
        output ROMINIT_READY, CPU_ACK, CPU_DOUT, VID_ACK, VID_DOUT,
               MEM_CE, MEM_WE, MEM_ADDR, MEM_DIN
    );

    modport master (
        output DL_ACTIVE, ROMINIT_SEL_BOOT, ROMINIT_SEL_CHR, ROMINIT_SEL_CART,
               ROMINIT_ADDR, ROMINIT_DATA, ROMINIT_VALID,
               CPU_REQ, CPU_WE, CPU_ADDR, CPU_DIN, VID_REQ, VID_ADDR, MEM_DOUT,
        input  ROMINIT_READY, CPU_ACK, CPU_DOUT, VID_ACK, VID_DOUT,
               MEM_CE, MEM_WE, MEM_ADDR, MEM_DIN
    );
endinterface

// File: rtl/scv_memarb.sv
// ----------------------------------------------------------------------------
// scv_memarb
// Arbiter/sequencer sharing one single-port RAM between the ROM download
// stream, the CPU and video fetch. Every requester-facing output is a flop.
//   CLK  : system clock
//   RESB : asynchronous active-low reset
//   bus  : scv_memarb_if.slave (requester ports + RAM port)
// Occupancy: writes IDLE->ACC (2 cycles), reads IDLE->ACC->RSP (3 cycles).
// ----------------------------------------------------------------------------
module scv_memarb #(
    parameter int            AW        = 18,
    parameter int            DW        = 8,
    parameter logic [AW-1:0] BOOT_BASE = AW'(18'h20000),
    parameter logic [AW-1:0] CHR_BASE  = AW'(18'h21000),
    parameter logic [AW-1:0] CART_BASE = AW'(18'h00000)
) (
    input  logic        CLK,
    input  logic        RESB,
    scv_memarb_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACC, RSP} state_e;
    typedef enum logic [1:0] {OWN_ROM, OWN_CPU, OWN_VID} own_e;

    state_e        state_q, state_d;
    own_e          own_q, own_d;
    logic          vid_last_q, vid_last_d;   // 1: VID had the last CPU/VID grant
    logic          mem_ce_q, mem_ce_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_din_q, mem_din_d;
    logic          rom_rdy_q, rom_rdy_d;
    logic          cpu_ack_q, cpu_ack_d;
    logic          vid_ack_q, vid_ack_d;
    logic [DW-1:0] cpu_dout_q, cpu_dout_d;
    logic [DW-1:0] vid_dout_q, vid_dout_d;

    // Download stream address decode, BOOT > CHR > CART.
    logic          rom_hit;
    logic [AW-1:0] rom_addr;
    always_comb begin
        rom_hit  = 1'b1;
        rom_addr = '0;
        if (bus.ROMINIT_SEL_BOOT)
            rom_addr = BOOT_BASE + AW'(bus.ROMINIT_ADDR[11:0]);
        else if (bus.ROMINIT_SEL_CHR)
            rom_addr = CHR_BASE + AW'(bus.ROMINIT_ADDR[11:0]);
        else if (bus.ROMINIT_SEL_CART)
            rom_addr = CART_BASE + AW'(bus.ROMINIT_ADDR);
        else
            rom_hit = 1'b0;
    end

    // A requester still seeing its completion pulse is treated as idle, so a
    // held REQ is not mistaken for a fresh request.
    logic rom_el, cpu_el, vid_el, cpu_wins;
    assign rom_el   = bus.ROMINIT_VALID & ~rom_rdy_q;
    assign cpu_el   = bus.CPU_REQ & ~cpu_ack_q & ~bus.DL_ACTIVE;
    assign vid_el   = bus.VID_REQ & ~vid_ack_q & ~bus.DL_ACTIVE;
    assign cpu_wins = cpu_el & (~vid_el | vid_last_q);

    always_comb begin
        state_d    = state_q;
        own_d      = own_q;
        vid_last_d = vid_last_q;
        mem_ce_d   = 1'b0;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        rom_rdy_d  = 1'b0;
        cpu_ack_d  = 1'b0;
        vid_ack_d  = 1'b0;
        cpu_dout_d = cpu_dout_q;
        vid_dout_d = vid_dout_q;
        case (state_q)
            IDLE: begin
                if (rom_el) begin
                    // Unselected writes still walk through ACC and get READY,
                    // but never touch the RAM.
                    state_d   = ACC;
                    own_d     = OWN_ROM;
                    rom_rdy_d = 1'b1;
                    mem_ce_d  = rom_hit;
                    mem_we_d  = rom_hit;
                    if (rom_hit) begin
                        mem_addr_d = rom_addr;
                        mem_din_d  = bus.ROMINIT_DATA;
                    end
                end else if (cpu_wins) begin
                    state_d    = ACC;
                    own_d      = OWN_CPU;
                    vid_last_d = 1'b0;
                    mem_ce_d   = 1'b1;
                    mem_we_d   = bus.CPU_WE;
                    mem_addr_d = bus.CPU_ADDR;
                    cpu_ack_d  = bus.CPU_WE;
                    if (bus.CPU_WE)
                        mem_din_d = bus.CPU_DIN;
                end else if (vid_el) begin
                    state_d    = ACC;
                    own_d      = OWN_VID;
                    vid_last_d = 1'b1;
                    mem_ce_d   = 1'b1;
                    mem_addr_d = bus.VID_ADDR;
                end
            end
            ACC: begin
                state_d = (own_q == OWN_ROM || mem_we_q) ? IDLE : RSP;
            end
            RSP: begin
                state_d = IDLE;
                if (own_q == OWN_CPU) begin
                    cpu_dout_d = bus.MEM_DOUT;
                    cpu_ack_d  = 1'b1;
                end else begin
                    vid_dout_d = bus.MEM_DOUT;
                    vid_ack_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESB) begin
        if (!RESB) begin
            state_q    <= IDLE;
            own_q      <= OWN_ROM;
            vid_last_q <= 1'b1;
            mem_ce_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            rom_rdy_q  <= 1'b0;
            cpu_ack_q  <= 1'b0;
            vid_ack_q  <= 1'b0;
            cpu_dout_q <= '0;
            vid_dout_q <= '0;
        end else begin
            state_q    <= state_d;
            own_q      <= own_d;
            vid_last_q <= vid_last_d;
            mem_ce_q   <= mem_ce_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            rom_rdy_q  <= rom_rdy_d;
            cpu_ack_q  <= cpu_ack_d;
            vid_ack_q  <= vid_ack_d;
            cpu_dout_q <= cpu_dout_d;
            vid_dout_q <= vid_dout_d;
        end
    end

    assign bus.MEM_CE        = mem_ce_q;
    assign bus.MEM_WE        = mem_we_q;
    assign bus.MEM_ADDR      = mem_addr_q;
    assign bus.MEM_DIN       = mem_din_q;
    assign bus.ROMINIT_READY = rom_rdy_q;
    assign bus.CPU_ACK       = cpu_ack_q;
    assign bus.CPU_DOUT      = cpu_dout_q;
    assign bus.VID_ACK       = vid_ack_q;
    assign bus.VID_DOUT      = vid_dout_q;
endmodule

// File: tb/tb_scv_memarb.sv
`timescale 1ns/1ps
module tb_scv_memarb;
    localparam int          AW        = 18;
    localparam int          DW        = 8;
    localparam logic [17:0] BOOT_BASE = 18'h20000;
    localparam logic [17:0] CHR_BASE  = 18'h21000;
    localparam logic [17:0] CART_BASE = 18'h00000;
    localparam logic [17:0] CADDR     = 18'h01234;
    localparam logic [17:0] VADDR     = 18'h00456;

    logic CLK = 1'b0;
    logic RESB;
    always #5 CLK = ~CLK;

    scv_memarb_if #(.AW(AW), .DW(DW)) bus();
    scv_memarb #(.AW(AW), .DW(DW), .BOOT_BASE(BOOT_BASE), .CHR_BASE(CHR_BASE),
                 .CART_BASE(CART_BASE)) dut (.CLK(CLK), .RESB(RESB), .bus(bus));

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] init_val(input int a);
        return 8'((a * 37) ^ (a >> 7));
    endfunction

    // ---------------- RAM behind the arbiter ----------------
    logic [7:0] ram [0:(1<<18)-1];
    logic [7:0] ram_q = '0;
    assign bus.MEM_DOUT = ram_q;
    initial begin
        for (int i = 0; i < (1<<18); i++) ram[i] = init_val(i);
        ram[CADDR] = 8'h3C;
        forever begin
            @(posedge CLK);
            if (bus.MEM_CE) begin
                if (bus.MEM_WE) ram[bus.MEM_ADDR] = bus.MEM_DIN;
                else            ram_q <= ram[bus.MEM_ADDR];
            end
        end
    end

    // ---------------- Transaction-level reference model ----------------
    // Each grant schedules its visible effects at fixed cycle offsets.
    typedef struct {
        bit         ce, we, rdy, cack, vack, cset, vset;
        logic [17:0] addr;
        logic [7:0]  din, cd, vd;
    } ev_t;
    ev_t        ev [8];
    ev_t        cur;
    logic [7:0] ref_mem [0:(1<<18)-1];
    int         cyc, free_at;
    bit         vid_last;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) ev[i] = '{default: '0};
        cur      = '{default: '0};
        cyc      = 0;
        free_at  = 0;
        vid_last = 1'b1;
    endtask

    task automatic decide();
        int s1, s3;
        logic [17:0] a;
        bit hit, c, v;
        s1 = (cyc + 1) % 8;
        s3 = (cyc + 3) % 8;
        if (bus.ROMINIT_VALID && !cur.rdy) begin
            hit = 1'b1;
            a   = '0;
            if (bus.ROMINIT_SEL_BOOT)      a = 18'(int'(BOOT_BASE) + int'(bus.ROMINIT_ADDR) % 4096);
            else if (bus.ROMINIT_SEL_CHR)  a = 18'(int'(CHR_BASE) + int'(bus.ROMINIT_ADDR) % 4096);
            else if (bus.ROMINIT_SEL_CART) a = 18'(int'(CART_BASE) + int'(bus.ROMINIT_ADDR));
            else hit = 1'b0;
            ev[s1].rdy = 1'b1;
            ev[s1].ce = hit; ev[s1].we = hit; ev[s1].addr = a; ev[s1].din = bus.ROMINIT_DATA;
            free_at = cyc + 2;
        end else if (!bus.DL_ACTIVE) begin
            c = bus.CPU_REQ && !cur.cack;
            v = bus.VID_REQ && !cur.vack;
            if (c && (!v || vid_last)) begin
                vid_last = 1'b0;
                ev[s1].ce = 1'b1; ev[s1].addr = bus.CPU_ADDR;
                if (bus.CPU_WE) begin
                    ev[s1].we = 1'b1; ev[s1].din = bus.CPU_DIN; ev[s1].cack = 1'b1;
                    free_at = cyc + 2;
                end else begin
                    ev[s3].cack = 1'b1; ev[s3].cset = 1'b1; ev[s3].cd = ref_mem[bus.CPU_ADDR];
                    free_at = cyc + 3;
                end
            end else if (v) begin
                vid_last = 1'b1;
                ev[s1].ce = 1'b1; ev[s1].addr = bus.VID_ADDR;
                ev[s3].vack = 1'b1; ev[s3].vset = 1'b1; ev[s3].vd = ref_mem[bus.VID_ADDR];
                free_at = cyc + 3;
            end
        end
    endtask

    initial begin
        ev_t e;
        for (int i = 0; i < (1<<18); i++) ref_mem[i] = init_val(i);
        ref_mem[CADDR] = 8'h3C;
        model_reset();
        forever begin
            @(posedge CLK or negedge RESB);
            if (!RESB) begin
                model_reset();
            end else begin
                if (cur.we) ref_mem[cur.addr] = cur.din;
                if (cyc >= free_at) decide();
                cyc++;
                e = ev[cyc % 8];
                ev[cyc % 8] = '{default: '0};
                cur.ce = e.ce; cur.we = e.we; cur.rdy = e.rdy;
                cur.cack = e.cack; cur.vack = e.vack;
                if (e.ce)   cur.addr = e.addr;
                if (e.we)   cur.din  = e.din;
                if (e.cset) cur.cd   = e.cd;
                if (e.vset) cur.vd   = e.vd;
            end
        end
    end

    // ---------------- Per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge CLK);
            if (chk_en) begin
                chk("mdl_ce",  32'(bus.MEM_CE),        32'(cur.ce));
                chk("mdl_we",  32'(bus.MEM_WE),        32'(cur.we));
                if (cur.ce) chk("mdl_addr", 32'(bus.MEM_ADDR), 32'(cur.addr));
                if (cur.we) chk("mdl_din",  32'(bus.MEM_DIN),  32'(cur.din));
                chk("mdl_rdy",  32'(bus.ROMINIT_READY), 32'(cur.rdy));
                chk("mdl_cack", 32'(bus.CPU_ACK),       32'(cur.cack));
                chk("mdl_vack", 32'(bus.VID_ACK),       32'(cur.vack));
                chk("mdl_cdout", 32'(bus.CPU_DOUT),     32'(cur.cd));
                chk("mdl_vdout", 32'(bus.VID_DOUT),     32'(cur.vd));
            end
        end
    end

    // ---------------- Stimulus ----------------
    task automatic step(input int k);
        repeat (k) begin @(posedge CLK); #1; end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ce"},   32'(bus.MEM_CE), 0);
        chk({tag, "_we"},   32'(bus.MEM_WE), 0);
        chk({tag, "_addr"}, 32'(bus.MEM_ADDR), 0);
        chk({tag, "_din"},  32'(bus.MEM_DIN), 0);
        chk({tag, "_rdy"},  32'(bus.ROMINIT_READY), 0);
        chk({tag, "_cack"}, 32'(bus.CPU_ACK), 0);
        chk({tag, "_vack"}, 32'(bus.VID_ACK), 0);
        chk({tag, "_cdout"}, 32'(bus.CPU_DOUT), 0);
        chk({tag, "_vdout"}, 32'(bus.VID_DOUT), 0);
    endtask

    function automatic logic [17:0] rand_addr();
        case ($urandom_range(0, 2))
            0:       return 18'($urandom_range(0, 255)) + CART_BASE;
            1:       return 18'($urandom_range(0, 255)) + BOOT_BASE;
            default: return 18'($urandom_range(0, 255)) + CHR_BASE;
        endcase
    endfunction

    initial begin
        RESB = 1'b0;
        bus.DL_ACTIVE = 0; bus.ROMINIT_VALID = 0;
        bus.ROMINIT_SEL_BOOT = 0; bus.ROMINIT_SEL_CHR = 0; bus.ROMINIT_SEL_CART = 0;
        bus.ROMINIT_ADDR = '0; bus.ROMINIT_DATA = '0;
        bus.CPU_REQ = 0; bus.CPU_WE = 0; bus.CPU_ADDR = '0; bus.CPU_DIN = '0;
        bus.VID_REQ = 0; bus.VID_ADDR = '0;
        step(3);
        chk_en = 1'b1;
        chk_zero("rst");
        RESB = 1'b1;

        // CHR write, then a back-to-back second write
        bus.ROMINIT_VALID = 1; bus.ROMINIT_SEL_CHR = 1;
        bus.ROMINIT_ADDR = 17'h1005; bus.ROMINIT_DATA = 8'hA5;
        step(1);
        chk("chr_ce", 32'(bus.MEM_CE), 1);
        chk("chr_we", 32'(bus.MEM_WE), 1);
        chk("chr_addr", 32'(bus.MEM_ADDR), 32'h21005);
        chk("chr_din", 32'(bus.MEM_DIN), 32'hA5);
        chk("chr_rdy", 32'(bus.ROMINIT_READY), 1);
        bus.ROMINIT_DATA = 8'h5A;
        step(1);
        chk("chr_rdy_gap", 32'(bus.ROMINIT_READY), 0);
        chk("chr_ce_gap", 32'(bus.MEM_CE), 0);
        step(1);
        chk("chr_rdy2", 32'(bus.ROMINIT_READY), 1);
        chk("chr_din2", 32'(bus.MEM_DIN), 32'h5A);
        bus.ROMINIT_VALID = 0; bus.ROMINIT_SEL_CHR = 0;
        step(2);

        // BOOT beats CART, 4 KiB wrap; then an unselected write
        bus.ROMINIT_VALID = 1; bus.ROMINIT_SEL_BOOT = 1; bus.ROMINIT_SEL_CART = 1;
        bus.ROMINIT_ADDR = 17'h0F123; bus.ROMINIT_DATA = 8'h77;
        step(1);
        chk("boot_addr", 32'(bus.MEM_ADDR), 32'h20123);
        chk("boot_ce", 32'(bus.MEM_CE), 1);
        bus.ROMINIT_VALID = 0; bus.ROMINIT_SEL_BOOT = 0; bus.ROMINIT_SEL_CART = 0;
        step(1);
        bus.ROMINIT_VALID = 1;
        step(1);
        chk("nosel_rdy", 32'(bus.ROMINIT_READY), 1);
        chk("nosel_ce", 32'(bus.MEM_CE), 0);
        bus.ROMINIT_VALID = 0;
        step(2);

        // CPU/VID read contention, round robin
        bus.CPU_REQ = 1; bus.CPU_WE = 0; bus.CPU_ADDR = CADDR;
        bus.VID_REQ = 1; bus.VID_ADDR = VADDR;
        step(1);
        chk("rr1_addr", 32'(bus.MEM_ADDR), 32'(CADDR));
        chk("rr1_we", 32'(bus.MEM_WE), 0);
        step(2);
        chk("rr1_cack", 32'(bus.CPU_ACK), 1);
        chk("rr1_cdout", 32'(bus.CPU_DOUT), 32'h3C);
        step(1);
        chk("rr2_addr", 32'(bus.MEM_ADDR), 32'(VADDR));
        step(2);
        chk("rr2_vack", 32'(bus.VID_ACK), 1);
        chk("rr2_vdout", 32'(bus.VID_DOUT), 32'(init_val(int'(VADDR))));
        step(1);
        chk("rr3_addr", 32'(bus.MEM_ADDR), 32'(CADDR));
        step(2);
        chk("rr3_cack", 32'(bus.CPU_ACK), 1);
        bus.CPU_REQ = 0;
        step(1);
        chk("rr4_addr", 32'(bus.MEM_ADDR), 32'(VADDR));
        step(2);
        chk("rr4_vack", 32'(bus.VID_ACK), 1);
        bus.VID_REQ = 0;

        // DL_ACTIVE blocks the CPU
        bus.DL_ACTIVE = 1; bus.CPU_REQ = 1; bus.CPU_WE = 1;
        bus.CPU_ADDR = 18'h00200; bus.CPU_DIN = 8'hE1;
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("dl_ce", 32'(bus.MEM_CE), 0);
            chk("dl_cack", 32'(bus.CPU_ACK), 0);
        end
        bus.DL_ACTIVE = 0;
        step(1);
        chk("dl_rel_ce", 32'(bus.MEM_CE), 1);
        chk("dl_rel_addr", 32'(bus.MEM_ADDR), 32'h00200);
        chk("dl_rel_cack", 32'(bus.CPU_ACK), 1);
        bus.CPU_REQ = 0;
        step(1);

        // ROMINIT arriving while a VID read is in ACC
        bus.VID_REQ = 1; bus.VID_ADDR = VADDR;
        step(1);
        chk("vr_addr", 32'(bus.MEM_ADDR), 32'(VADDR));
        bus.ROMINIT_VALID = 1; bus.ROMINIT_SEL_BOOT = 1;
        bus.ROMINIT_ADDR = 17'h00042; bus.ROMINIT_DATA = 8'h99;
        step(1);
        chk("vr_rdy_early", 32'(bus.ROMINIT_READY), 0);
        step(1);
        chk("vr_vack", 32'(bus.VID_ACK), 1);
        bus.VID_REQ = 0;
        step(1);
        chk("vr_rdy", 32'(bus.ROMINIT_READY), 1);
        chk("vr_rom_addr", 32'(bus.MEM_ADDR), 32'h20042);
        bus.ROMINIT_VALID = 0; bus.ROMINIT_SEL_BOOT = 0;
        step(1);

        // Reset during RSP of a CPU read
        bus.CPU_REQ = 1; bus.CPU_WE = 0; bus.CPU_ADDR = CADDR;
        step(2);
        RESB = 1'b0;
        #1;
        chk_zero("mid_rst");
        bus.CPU_REQ = 0;
        step(2);
        RESB = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk("post_rst_cack", 32'(bus.CPU_ACK), 0);
        end
        bus.CPU_REQ = 1; bus.VID_REQ = 1; bus.VID_ADDR = VADDR;
        step(1);
        chk("post_rst_tie", 32'(bus.MEM_ADDR), 32'(CADDR));
        step(2);
        bus.CPU_REQ = 0;
        step(3);
        bus.VID_REQ = 0;
        step(2);

        // Randomized traffic
        for (int k = 0; k < 4000; k++) begin
            step(1);
            if ($urandom_range(0, 31) == 0) bus.DL_ACTIVE = ~bus.DL_ACTIVE;
            if (bus.ROMINIT_VALID && bus.ROMINIT_READY) bus.ROMINIT_VALID = 0;
            if (!bus.ROMINIT_VALID && $urandom_range(0, 5) == 0) begin
                bus.ROMINIT_VALID = 1;
                {bus.ROMINIT_SEL_BOOT, bus.ROMINIT_SEL_CHR, bus.ROMINIT_SEL_CART} = 3'($urandom_range(0, 7));
                bus.ROMINIT_ADDR = (17'($urandom_range(0, 31)) << 12) | 17'($urandom_range(0, 255));
                bus.ROMINIT_DATA = 8'($urandom);
            end else if (bus.ROMINIT_VALID && $urandom_range(0, 15) == 0) begin
                bus.ROMINIT_DATA = 8'($urandom);
            end
            if (bus.CPU_REQ && bus.CPU_ACK) bus.CPU_REQ = 0;
            if (!bus.CPU_REQ && $urandom_range(0, 2) == 0) begin
                bus.CPU_REQ = 1; bus.CPU_WE = 1'($urandom_range(0, 1));
                bus.CPU_ADDR = rand_addr(); bus.CPU_DIN = 8'($urandom);
            end else if (bus.CPU_REQ && $urandom_range(0, 15) == 0) begin
                bus.CPU_ADDR = rand_addr(); bus.CPU_DIN = 8'($urandom);
            end
            if (bus.VID_REQ && bus.VID_ACK) bus.VID_REQ = 0;
            if (!bus.VID_REQ && $urandom_range(0, 2) == 0) begin
                bus.VID_REQ = 1; bus.VID_ADDR = rand_addr();
            end else if (bus.VID_REQ && $urandom_range(0, 15) == 0) begin
                bus.VID_ADDR = rand_addr();
            end
        end
        bus.ROMINIT_VALID = 0; bus.CPU_REQ = 0; bus.VID_REQ = 0;
        step(6);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
